load_store_unit: RTL and testbench

//   Memory-stage load/store engine between the pipeline MEM stage and the word-addressed data memory.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_load_align.sv | 43 ++++
 rtl/load_store_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the sub-word store merge helper.
package lsu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned F3_WIDTH = 3;

    localparam logic [F3_WIDTH-1:0] F3_B  = 3'b000;
    localparam logic [F3_WIDTH-1:0] F3_H  = 3'b001;
    localparam logic [F3_WIDTH-1:0] F3_W  = 3'b010;
    localparam logic [F3_WIDTH-1:0] F3_BU = 3'b100;
    localparam logic [F3_WIDTH-1:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RMW_READ = 3'd2,
        S_WRITE    = 3'd3,
        S_RESP     = 3'd4
    } lsu_state_t;

    // Replace one byte (SB) or one half (SH) lane of old_word, keeping the rest.
    function automatic logic [XLEN-1:0] store_merge(
        input logic [XLEN-1:0]     old_word,
        input logic [15:0]         data,
        input logic [1:0]          off,
        input logic [F3_WIDTH-1:0] funct3
    );
        logic [XLEN-1:0] w;
        w = old_word;
        if (funct3 == F3_B) begin
            case (off)
                2'd0:    w[7:0]   = data[7:0];
                2'd1:    w[15:8]  = data[7:0];
                2'd2:    w[23:16] = data[7:0];
                default: w[31:24] = data[7:0];
            endcase
        end else if (off[1]) begin
            w[31:16] = data;
        end else begin
            w[15:0] = data;
        end
        return w;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the byte/half lane of a memory word and
// sign- or zero-extends it according to the RV32I load width code.
// Ports:
//   word_i    memory word as read
//   off_i     byte offset within the word (addr[1:0])
//   funct3_i  load width code
//   data_o    extended 32-bit load value (0 for an unknown width code)
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0]     word_i,
    input  logic [1:0]          off_i,
    input  logic [F3_WIDTH-1:0] funct3_i,
    output logic [XLEN-1:0]     data_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    // Lane selection
    always_comb begin
        case (off_i)
            2'd0:    byte_c = word_i[7:0];
            2'd1:    byte_c = word_i[15:8];
            2'd2:    byte_c = word_i[23:16];
            default: byte_c = word_i[31:24];
        endcase
        half_c = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Extension
    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{byte_c[7]}}, byte_c};
            F3_H:    data_o = {{16{half_c[15]}}, half_c};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'd0, byte_c};
            F3_HU:   data_o = {16'd0, half_c};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine for a word-addressed data memory.
// One request per handshake; SB/SH use read-modify-write. All outputs are
// registered.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned H/HU/SH and
// W/SW accesses are reported as errors; otherwise the low address bits are
// cleared and the access proceeds.
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   req_*_i / req_ready_o    request channel (is_store, funct3, addr, wdata)
//   resp_*_o / resp_ready_i  response channel (rdata, error)
//   dmem_*                   memory read/write enables, word address, write
//                            data, combinational read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_is_store_i,
    input  logic [F3_WIDTH-1:0] req_funct3_i,
    input  logic [XLEN-1:0]     req_addr_i,
    input  logic [XLEN-1:0]     req_wdata_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [XLEN-1:0]     resp_rdata_o,
    output logic                resp_error_o,
    output logic                dmem_read_enable_o,
    output logic                dmem_write_enable_o,
    output logic [XLEN-1:0]     dmem_address_o,
    output logic [XLEN-1:0]     dmem_write_data_o,
    input  logic [XLEN-1:0]     dmem_read_data_i
);

    localparam logic [XLEN-1:0] DMEM_WORDS_W = XLEN'(DMEM_WORDS);

    lsu_state_t          state_q, state_d;
    logic [F3_WIDTH-1:0] funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic [15:0]         sdata_q, sdata_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]     resp_rdata_q, resp_rdata_d;
    logic                resp_error_q, resp_error_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_en_q, wr_en_d;
    logic [XLEN-1:0]     dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]     dmem_wdata_q, dmem_wdata_d;

    logic                is_half_c, is_word_c;
    logic                illegal_c, range_err_c, misalign_c, req_err_c;
    logic [XLEN-1:0]     eff_addr_c;
    logic [XLEN-1:0]     load_data_c;
    logic [XLEN-1:0]     merge_c;

    // Request decode and error checking on the incoming request
    always_comb begin
        is_half_c  = (req_funct3_i == F3_H) || (!req_is_store_i && (req_funct3_i == F3_HU));
        is_word_c  = (req_funct3_i == F3_W);
        eff_addr_c = req_addr_i;
        if (req_is_store_i) begin
            illegal_c = (req_funct3_i > F3_W);
        end else begin
            illegal_c = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                        (req_funct3_i == 3'b111);
        end
        range_err_c = ((req_addr_i >> 2) >= DMEM_WORDS_W);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_c = (is_half_c && req_addr_i[0]) ||
                     (is_word_c && (req_addr_i[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
        // Silently align: drop the offending low address bits
        if (is_half_c) eff_addr_c[0]   = 1'b0;
        if (is_word_c) eff_addr_c[1:0] = 2'b00;
`endif
        req_err_c = illegal_c || range_err_c || misalign_c;
    end

    lsu_load_align u_load_align (
        .word_i   (dmem_read_data_i),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .data_o   (load_data_c)
    );

    // Sub-word store merge with the word just read
    always_comb begin
        merge_c = store_merge(dmem_read_data_i, sdata_q, off_q, funct3_q);
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            funct3_q     <= '0;
            off_q        <= '0;
            sdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            sdata_q      <= sdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        sdata_d      = sdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    funct3_d     = req_funct3_i;
                    off_d        = eff_addr_c[1:0];
                    sdata_d      = req_wdata_i[15:0];
                    req_ready_d  = 1'b0;
                    resp_rdata_d = '0;
                    resp_error_d = 1'b0;
                    if (req_err_c) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else if (!req_is_store_i) begin
                        state_d     = S_LOAD;
                        rd_en_d     = 1'b1;
                        dmem_addr_d = eff_addr_c >> 2;
                    end else if (is_word_c) begin
                        state_d      = S_WRITE;
                        wr_en_d      = 1'b1;
                        dmem_addr_d  = eff_addr_c >> 2;
                        dmem_wdata_d = req_wdata_i;
                    end else begin
                        state_d     = S_RMW_READ;
                        rd_en_d     = 1'b1;
                        dmem_addr_d = eff_addr_c >> 2;
                    end
                end
            end
            S_LOAD: begin
                state_d      = S_RESP;
                resp_rdata_d = load_data_c;
                resp_valid_d = 1'b1;
                rd_en_d      = 1'b0;
                dmem_addr_d  = '0;
            end
            S_RMW_READ: begin
                // Address is kept for the following write
                state_d      = S_WRITE;
                rd_en_d      = 1'b0;
                wr_en_d      = 1'b1;
                dmem_wdata_d = merge_c;
            end
            S_WRITE: begin
                state_d      = S_RESP;
                wr_en_d      = 1'b0;
                dmem_addr_d  = '0;
                dmem_wdata_d = '0;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_error_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                rd_en_d      = 1'b0;
                wr_en_d      = 1'b0;
                dmem_addr_d  = '0;
                dmem_wdata_d = '0;
            end
        endcase
    end

    assign req_ready_o         = req_ready_q;
    assign resp_valid_o        = resp_valid_q;
    assign resp_rdata_o        = resp_rdata_q;
    assign resp_error_o        = resp_error_q;
    assign dmem_read_enable_o  = rd_en_q;
    assign dmem_write_enable_o = wr_en_q;
    assign dmem_address_o      = dmem_addr_q;
    assign dmem_write_data_o   = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 1024-word behavioural memory, a table of
// directed requests with hand-computed results, plus back-pressure and
// reset-during-RMW sequences.
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        dmem_read_enable;
    logic        dmem_write_enable;
    logic [31:0] dmem_address;
    logic [31:0] dmem_write_data;
    logic [31:0] dmem_read_data;

    logic [31:0] mem [0:1023];
    logic        mem_init;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    load_store_unit dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_is_store_i      (req_is_store),
        .req_funct3_i        (req_funct3),
        .req_addr_i          (req_addr),
        .req_wdata_i         (req_wdata),
        .resp_valid_o        (resp_valid),
        .resp_ready_i        (resp_ready),
        .resp_rdata_o        (resp_rdata),
        .resp_error_o        (resp_error),
        .dmem_read_enable_o  (dmem_read_enable),
        .dmem_write_enable_o (dmem_write_enable),
        .dmem_address_o      (dmem_address),
        .dmem_write_data_o   (dmem_write_data),
        .dmem_read_data_i    (dmem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory: combinational read, write on rising edge
    assign dmem_read_data = (dmem_address < 32'd1024) ? mem[dmem_address[9:0]] : 32'd0;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            mem[2]    <= 32'h1122_3344;
            mem[3]    <= 32'h1122_3344;
            mem[5]    <= 32'h8899_AABB;
            mem[1023] <= 32'h7FFF_1234;
        end else if (dmem_write_enable && (dmem_address < 32'd1024)) begin
            mem[dmem_address[9:0]] <= dmem_write_data;
        end
    end

    // Enable pulse counters
    always @(posedge clock) begin
        if (dmem_read_enable)  rd_cnt <= rd_cnt + 1;
        if (dmem_write_enable) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction; called with the DUT idle, #1 after a rising edge
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdata,
                          output logic err, output int lat, output logic rdy_after);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = a;
        req_wdata    = d;
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_error;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        rdy_after  = req_ready;
    endtask

    typedef struct {
        string       name;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic        chk_mem;
        int          mem_idx;
        logic [31:0] mem_exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] er,
                       input logic ee, input int el, input logic cm, input int mi,
                       input logic [31:0] me);
        vec_t v;
        v.name = n; v.st = st; v.f3 = f3; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
        v.chk_mem = cm; v.mem_idx = mi; v.mem_exp = me;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        logic        rdy;
        int          lat;
        int          rd0, wr0;

        reset = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;

        //   name        st    f3      addr          wdata          rdata          err  lat mem? idx  word
        add("lb_17",    1'b0, 3'b000, 32'h17,       32'h0,         32'hFFFF_FF88, 1'b0, 2, 1'b0, 0, 32'h0);
        add("lhu_14",   1'b0, 3'b101, 32'h14,       32'h0,         32'h0000_AABB, 1'b0, 2, 1'b0, 0, 32'h0);
        add("lh_16",    1'b0, 3'b001, 32'h16,       32'h0,         32'hFFFF_8899, 1'b0, 2, 1'b0, 0, 32'h0);
        add("lw_14",    1'b0, 3'b010, 32'h14,       32'h0,         32'h8899_AABB, 1'b0, 2, 1'b0, 0, 32'h0);
        add("lbu_15",   1'b0, 3'b100, 32'h15,       32'h0,         32'h0000_00AA, 1'b0, 2, 1'b0, 0, 32'h0);
        add("lb_14",    1'b0, 3'b000, 32'h14,       32'h0,         32'hFFFF_FFBB, 1'b0, 2, 1'b0, 0, 32'h0);
        add("sb_09",    1'b1, 3'b000, 32'h09,       32'hFFFF_FFEE, 32'h0,         1'b0, 3, 1'b1, 2, 32'h1122_EE44);
        add("sh_0e",    1'b1, 3'b001, 32'h0E,       32'hABCD_5566, 32'h0,         1'b0, 3, 1'b1, 3, 32'h5566_3344);
        add("sw_20",    1'b1, 3'b010, 32'h20,       32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1'b1, 8, 32'hDEAD_BEEF);
        add("lhu_ffe",  1'b0, 3'b101, 32'hFFE,      32'h0,         32'h0000_7FFF, 1'b0, 2, 1'b0, 0, 32'h0);
        add("lw_range", 1'b0, 3'b010, 32'h1000,     32'h0,         32'h0,         1'b1, 1, 1'b0, 0, 32'h0);
        add("sb_range", 1'b1, 3'b000, 32'hFFFF_FFF0,32'h0,         32'h0,         1'b1, 1, 1'b0, 0, 32'h0);
        add("ld_f3_011",1'b0, 3'b011, 32'h14,       32'h0,         32'h0,         1'b1, 1, 1'b0, 0, 32'h0);
        add("st_f3_100",1'b1, 3'b100, 32'h20,       32'h1234_5678, 32'h0,         1'b1, 1, 1'b1, 8, 32'hDEAD_BEEF);
`ifdef LSU_MISALIGN_TRAP_EN
        add("lw_15",    1'b0, 3'b010, 32'h15,       32'h0,         32'h0,         1'b1, 1, 1'b0, 0, 32'h0);
        add("lh_17",    1'b0, 3'b001, 32'h17,       32'h0,         32'h0,         1'b1, 1, 1'b0, 0, 32'h0);
        add("sw_0f",    1'b1, 3'b010, 32'h0F,       32'hCAFE_F00D, 32'h0,         1'b1, 1, 1'b1, 3, 32'h5566_3344);
`else
        add("lw_15",    1'b0, 3'b010, 32'h15,       32'h0,         32'h8899_AABB, 1'b0, 2, 1'b0, 0, 32'h0);
        add("lh_17",    1'b0, 3'b001, 32'h17,       32'h0,         32'hFFFF_8899, 1'b0, 2, 1'b0, 0, 32'h0);
        add("sw_0f",    1'b1, 3'b010, 32'h0F,       32'hCAFE_F00D, 32'h0,         1'b0, 2, 1'b1, 3, 32'hCAFE_F00D);
`endif

        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready",  32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_rd_en",      32'(dmem_read_enable), 32'd0);
        chk("rst_wr_en",      32'(dmem_write_enable), 32'd0);
        chk("rst_address",    dmem_address, 32'd0);
        chk("rst_wdata",      dmem_write_data, 32'd0);
        reset = 1'b0; mem_init = 1'b0;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            rd0 = rd_cnt; wr0 = wr_cnt;
            do_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rdata, err, lat, rdy);
            chk({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, "_error"}, 32'(err), 32'(vecs[i].exp_err));
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            chk({vecs[i].name, "_ready_after"}, 32'(rdy), 32'd1);
            if (vecs[i].exp_err) begin
                chk({vecs[i].name, "_no_read"}, 32'(rd_cnt - rd0), 32'd0);
                chk({vecs[i].name, "_no_write"}, 32'(wr_cnt - wr0), 32'd0);
            end
            if (vecs[i].chk_mem)
                chk({vecs[i].name, "_mem"}, mem[vecs[i].mem_idx], vecs[i].mem_exp);
        end

        // Back-pressure: response must hold while resp_ready stays low
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h17; req_wdata = 32'd0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        for (int c = 0; c < 4; c++) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, 32'hFFFF_FF88);
            chk("hold_error", 32'(resp_error), 32'd0);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk("hold_release_valid", 32'(resp_valid), 32'd0);
        chk("hold_release_ready", 32'(req_ready), 32'd1);

        // Reset while in RMW_READ: no write may follow
        wr0 = wr_cnt;
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h09; req_wdata = 32'h0000_0077;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("rmw_read_en", 32'(dmem_read_enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("rmw_rst_ready", 32'(req_ready), 32'd1);
        chk("rmw_rst_rd_en", 32'(dmem_read_enable), 32'd0);
        chk("rmw_rst_wr_en", 32'(dmem_write_enable), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rmw_rst_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rmw_rst_mem", mem[2], 32'h1122_EE44);
        chk("rmw_rst_resp_valid", 32'(resp_valid), 32'd0);

        // Unit is usable again after the reset
        do_req(1'b0, 3'b010, 32'h08, 32'd0, rdata, err, lat, rdy);
        chk("post_rst_lw", rdata, 32'h1122_EE44);
        chk("post_rst_lat", 32'(lat), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
